// File: rtl/sprite_compositor.sv
// Multi-sprite VGA pixel compositor: two-stage pipeline with index-priority layering,
// dashed centre net, frame-synchronous attribute shadows and ball-vs-sprite collision flags.
module sprite_compositor #(
  parameter int unsigned H_VIDEO     = 640,
  parameter int unsigned V_VIDEO     = 480,
  parameter int unsigned NUM_SPRITES = 4,
  parameter int unsigned COLOR_BITS  = 4,
  parameter int unsigned NET_WIDTH   = 12,
  parameter int unsigned NET_SEG     = 12,
  parameter int unsigned NET_PERIOD  = 24,
  parameter int unsigned NET_OFFSET  = 6
) (
  input  logic                                  clk_0,
  input  logic                                  rst,
  input  logic [9:0]                            pixel_x,
  input  logic [9:0]                            pixel_y,
  input  logic                                  video_on,
  input  logic                                  frame_start,
  input  logic [10*NUM_SPRITES-1:0]             spr_xpos,
  input  logic [10*NUM_SPRITES-1:0]             spr_ypos,
  input  logic [10*NUM_SPRITES-1:0]             spr_w,
  input  logic [10*NUM_SPRITES-1:0]             spr_h,
  input  logic [3*COLOR_BITS*NUM_SPRITES-1:0]   spr_color,
  input  logic [NUM_SPRITES-1:0]                spr_en,
  input  logic                                  net_en,
  input  logic [3*COLOR_BITS-1:0]               net_color,
  output logic [COLOR_BITS-1:0]                 red,
  output logic [COLOR_BITS-1:0]                 green,
  output logic [COLOR_BITS-1:0]                 blue,
  output logic [NUM_SPRITES-1:0]                collision
);

  localparam int unsigned CW     = 3 * COLOR_BITS;
  localparam int unsigned SW     = 10 * NUM_SPRITES;
  localparam int unsigned PW     = (NET_PERIOD > 1) ? $clog2(NET_PERIOD) : 1;
  localparam int unsigned NET_X0 = H_VIDEO / 2 - NET_WIDTH / 2;
  localparam int unsigned NET_X1 = H_VIDEO / 2 + NET_WIDTH / 2 - 1;
  localparam int unsigned PHASE0 = (NET_PERIOD - NET_OFFSET) % NET_PERIOD;

  logic [SW-1:0]             sh_xpos, sh_ypos, sh_w, sh_h;
  logic [CW*NUM_SPRITES-1:0] sh_color;
  logic [NUM_SPRITES-1:0]    sh_en;
  logic                      sh_net_en;
  logic [CW-1:0]             sh_net_color;

  logic [PW-1:0]             phase_q, phase_c;
  logic [NUM_SPRITES-1:0]    hit_c, hit_q;
  logic                      net_hit_c;
  logic [CW-1:0]             col_c, col_q;
  logic                      von_q;
  logic [NUM_SPRITES-1:0]    overlap_c, acc_q;

  // Attribute shadows: swapped only on frame_start so a frame is never torn
  always_ff @(posedge clk_0) begin
    if (rst) begin
      sh_xpos      <= '0;
      sh_ypos      <= '0;
      sh_w         <= '0;
      sh_h         <= '0;
      sh_color     <= '0;
      sh_en        <= '0;
      sh_net_en    <= 1'b0;
      sh_net_color <= '0;
    end else if (frame_start) begin
      sh_xpos      <= spr_xpos;
      sh_ypos      <= spr_ypos;
      sh_w         <= spr_w;
      sh_h         <= spr_h;
      sh_color     <= spr_color;
      sh_en        <= spr_en;
      sh_net_en    <= net_en;
      sh_net_color <= net_color;
    end
  end

  // Net line phase: value for the current line, used combinationally and then stored
  always_comb begin
    phase_c = phase_q;
    if (video_on && (pixel_x == 10'd0)) begin
      if (pixel_y == 10'd0)
        phase_c = PW'(PHASE0);
      else if (phase_q == PW'(NET_PERIOD - 1))
        phase_c = '0;
      else
        phase_c = phase_q + PW'(1);
    end
  end

  // Stage-1 hit tests in 11-bit arithmetic with exclusive end
  always_comb begin
    hit_c = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      hit_c[i] = sh_en[i]
        && ({1'b0, pixel_x} >= {1'b0, sh_xpos[10*i +: 10]})
        && ({1'b0, pixel_x} <  (11'(sh_xpos[10*i +: 10]) + 11'(sh_w[10*i +: 10])))
        && ({1'b0, pixel_y} >= {1'b0, sh_ypos[10*i +: 10]})
        && ({1'b0, pixel_y} <  (11'(sh_ypos[10*i +: 10]) + 11'(sh_h[10*i +: 10])));
    end
    net_hit_c = sh_net_en
      && (pixel_x >= 10'(NET_X0)) && (pixel_x <= 10'(NET_X1))
      && (pixel_y < 10'(V_VIDEO))
      && (phase_c < PW'(NET_SEG));
  end

  // Layer selection: lowest-index sprite over net over black
  always_comb begin
    col_c = net_hit_c ? sh_net_color : '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit_c[i]) col_c = sh_color[CW*i +: CW];
    end
  end

  always_ff @(posedge clk_0) begin
    if (rst) begin
      phase_q <= '0;
      hit_q   <= '0;
      col_q   <= '0;
      von_q   <= 1'b0;
    end else begin
      phase_q <= phase_c;
      hit_q   <= hit_c;
      col_q   <= col_c;
      von_q   <= video_on;
    end
  end

  always_comb begin
    overlap_c    = hit_q & {NUM_SPRITES{hit_q[0] & von_q}};
    overlap_c[0] = 1'b0;
  end

  // Stage 2 output and per-frame collision hand-off
  always_ff @(posedge clk_0) begin
    if (rst) begin
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      acc_q     <= '0;
      collision <= '0;
    end else begin
      red   <= von_q ? col_q[CW-1 -: COLOR_BITS]            : '0;
      green <= von_q ? col_q[2*COLOR_BITS-1 -: COLOR_BITS]  : '0;
      blue  <= von_q ? col_q[COLOR_BITS-1:0]                : '0;
      if (frame_start) begin
        collision <= acc_q;
        acc_q     <= overlap_c;
      end else begin
        acc_q <= acc_q | overlap_c;
      end
    end
  end

endmodule
